// File: rtl/weighted_mean_pkg.sv
// weighted_mean_pkg: shared widths, iteration count and FSM state type for weighted_mean_ctrl
package weighted_mean_pkg;
  localparam int DW_DEF    = 32;
  localparam int NCH_DEF   = 4;
  localparam int ACC_W     = 2 * DW_DEF + $clog2(NCH_DEF);
  localparam int WS_W      = DW_DEF + $clog2(NCH_DEF);
  localparam int DIV_ITERS = ACC_W;
  typedef enum logic [1:0] {IDLE, MAC, DIV, OUT} wm_state_e;
endpackage

// File: rtl/wm_serial_div.sv
// wm_serial_div: unsigned restoring divider, one quotient bit per cycle, MSB first
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load num/den and begin dividing (one-cycle pulse)
//   num, den   : dividend (AW bits) and divisor (SW bits), sampled on start
//   done       : high in the cycle whose edge produces the final quotient bit
//   quot       : low DW quotient bits, valid together with done
module wm_serial_div
  import weighted_mean_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF,
  localparam int AW = 2 * DW + $clog2(NCH),
  localparam int SW = DW + $clog2(NCH),
  localparam int CW = $clog2(AW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] num,
  input  logic [SW-1:0] den,
  output logic          done,
  output logic [DW-1:0] quot
);
  logic [AW-1:0] q_q, q_d;
  logic [SW-1:0] rem_q, rem_d, den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [SW:0]   rem_sh;
  logic          ge;
  // The dividend register doubles as the quotient register: each step shifts
  // the next dividend bit into the remainder and the new quotient bit in at the LSB.
  assign rem_sh = {rem_q, q_q[AW-1]};
  assign ge     = rem_sh >= {1'b0, den_q};
  always_comb begin
    rem_d = start ? '0 : run_q ? SW'(ge ? rem_sh - {1'b0, den_q} : rem_sh) : rem_q;
    q_d   = start ? num : run_q ? {q_q[AW-2:0], ge} : q_q;
    den_d = start ? den : den_q;
    cnt_d = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
    run_d = start || (run_q && cnt_q != CW'(AW - 1));
  end
  assign done = run_q && cnt_q == CW'(AW - 1);
  assign quot = q_d[DW-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rem_q <= rem_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/weighted_mean_ctrl.sv
// weighted_mean_ctrl: floor(sum(x_i*w_i)/sum(w_i)) over NCH channels, serial MAC then serial divide
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake; x_in/w_in captured when both high
//   x_in, w_in            : packed unsigned samples/weights, channel i at [i*DW +: DW]
//   out_valid/out_ready   : result handshake; mean/div_by_zero held until accepted
//   mean                  : truncated weighted mean (0 when all weights are zero)
//   div_by_zero           : every weight was zero
//   busy                  : FSM outside IDLE
module weighted_mean_ctrl
  import weighted_mean_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF,
  localparam int AW = 2 * DW + $clog2(NCH),
  localparam int SW = DW + $clog2(NCH),
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*DW-1:0] x_in,
  input  logic [NCH*DW-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     mean,
  output logic              div_by_zero,
  output logic              busy
);
  wm_state_e         state_q, state_d;
  logic [NCH*DW-1:0] x_q, x_d, w_q, w_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [SW-1:0]     wsum_q, wsum_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     mean_q, mean_d;
  logic              dz_q, dz_d;
  logic [DW-1:0]     x_sel, w_sel, div_quot;
  logic [2*DW-1:0]   prod;
  logic              last, div_start, div_done;
  // Single shared multiplier, fed by the channel selected by idx_q.
  assign x_sel = x_q[idx_q*DW +: DW];
  assign w_sel = w_q[idx_q*DW +: DW];
  assign prod  = {{DW{1'b0}}, x_sel} * {{DW{1'b0}}, w_sel};
  assign last  = idx_q == IW'(NCH - 1);
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    w_d       = w_q;
    acc_d     = acc_q;
    wsum_d    = wsum_q;
    idx_d     = idx_q;
    mean_d    = mean_q;
    dz_d      = dz_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = MAC;
        x_d     = x_in;
        w_d     = w_in;
        acc_d   = '0;
        wsum_d  = '0;
        idx_d   = '0;
      end
      MAC: begin
        acc_d  = acc_q + AW'(prod);
        wsum_d = wsum_q + SW'(w_sel);
        idx_d  = last ? '0 : idx_q + 1'b1;
        // The divider is loaded straight from the final accumulator sums so
        // its first iteration lands on the very next edge.
        if (last) begin
          state_d   = (wsum_d == '0) ? OUT : DIV;
          div_start = wsum_d != '0;
          mean_d    = '0;
          dz_d      = wsum_d == '0;
        end
      end
      DIV: if (div_done) begin
        state_d = OUT;
        mean_d  = div_quot;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  wm_serial_div #(.DW(DW), .NCH(NCH)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   (acc_d),
    .den   (wsum_d),
    .done  (div_done),
    .quot  (div_quot)
  );
  assign in_ready    = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign out_valid   = state_q == OUT;
  assign mean        = mean_q;
  assign div_by_zero = dz_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      wsum_q  <= '0;
      idx_q   <= '0;
      mean_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      wsum_q  <= wsum_d;
      idx_q   <= idx_d;
      mean_q  <= mean_d;
      dz_q    <= dz_d;
    end
  end
endmodule

// File: tb/tb_weighted_mean_ctrl.sv
// tb_weighted_mean_ctrl: scoreboard bench for weighted_mean_ctrl (latency, results, backpressure, reset)
module tb_weighted_mean_ctrl;
  localparam int DW  = 32;
  localparam int NCH = 4;
  typedef struct packed {logic [DW-1:0] mean; logic dz;} res_t;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [NCH*DW-1:0] x_in = '0;
  logic [NCH*DW-1:0] w_in = '0;
  logic              in_ready, out_valid, div_by_zero, busy;
  logic [DW-1:0]     mean;
  res_t              sb[$];
  int                checks = 0;
  int                failures = 0;
  always #5 clk = ~clk;
  weighted_mean_ctrl #(.DW(DW), .NCH(NCH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x_in        (x_in),
    .w_in        (w_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mean        (mean),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [NCH*DW-1:0] xp, input logic [NCH*DW-1:0] wp);
    logic [2*DW+1:0] num;
    logic [2*DW+1:0] den;
    res_t r;
    num = '0;
    den = '0;
    for (int i = 0; i < NCH; i++) begin
      num += (2*DW+2)'(xp[i*DW +: DW]) * (2*DW+2)'(wp[i*DW +: DW]);
      den += (2*DW+2)'(wp[i*DW +: DW]);
    end
    r.dz   = den == '0;
    r.mean = r.dz ? '0 : DW'(num / den);
    return r;
  endfunction
  task automatic send(input string tag, input logic [NCH*DW-1:0] xp, input logic [NCH*DW-1:0] wp);
    int n;
    x_in = xp;
    w_in = wp;
    in_valid = 1'b1;
    sb.push_back(model(xp, wp));
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_accept"}, 64'(n < 200), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_out(input string tag, input int cyc);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      if (n == 2) begin
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_inrdy"}, 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n + 1), 64'(cyc));
  endtask
  task automatic consume(input string tag);
    res_t e;
    chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_mean"}, 64'(mean), 64'(e.mean));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovdrop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask
  initial begin
    logic [NCH*DW-1:0] xp, wp;
    res_t e;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_inrdy", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_mean", 64'(mean), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    send("avg", {32'd40, 32'd30, 32'd20, 32'd10}, {4{32'd1}});
    wait_out("avg", 71);
    consume("avg");
    send("trunc", {32'd4, 32'd3, 32'd2, 32'd1}, {32'd3, 32'd1, 32'd3, 32'd2});
    wait_out("trunc", 71);
    consume("trunc");
    send("zero", {32'hdead, 32'h1234, 32'h7, 32'hffff_ffff}, '0);
    wait_out("zero", 5);
    consume("zero");
    send("max", {4{32'hffff_ffff}}, {4{32'hffff_ffff}});
    wait_out("max", 71);
    consume("max");
    send("hold", {32'd400, 32'd300, 32'd200, 32'd100}, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_out("hold", 71);
    xp = {32'd9, 32'd8, 32'd7, 32'd6};
    wp = {32'd1, 32'd0, 32'd5, 32'd2};
    x_in = xp;
    w_in = wp;
    in_valid = 1'b1;
    sb.push_back(model(xp, wp));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_mean", 64'(mean), 64'(sb[0].mean));
      chk("hold_inrdy", 64'(in_ready), 64'd0);
      chk("hold_ov", 64'(out_valid), 64'd1);
    end
    consume("hold");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second_busy", 64'(busy), 64'd1);
    wait_out("second", 71);
    consume("second");
    send("rstdiv", {32'd50, 32'd60, 32'd70, 32'd80}, {4{32'd2}});
    repeat (29) begin
      @(posedge clk); #1;
    end
    chk("rstdiv_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("rstdiv_inrdy", 64'(in_ready), 64'd1);
    chk("rstdiv_idle", 64'(busy), 64'd0);
    chk("rstdiv_ov", 64'(out_valid), 64'd0);
    chk("rstdiv_mean", 64'(mean), 64'd0);
    chk("rstdiv_dz", 64'(div_by_zero), 64'd0);
    send("after_rst", {32'd1000, 32'd3, 32'd77, 32'd12}, {32'd7, 32'd0, 32'd11, 32'd5});
    wait_out("after_rst", 71);
    consume("after_rst");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NCH; i++) begin
        xp[i*DW +: DW] = $urandom();
        wp[i*DW +: DW] = (k == 3) ? 32'd0 : ((k & 1) != 0 ? $urandom() : 32'($urandom_range(0, 3)));
      end
      send("rand", xp, wp);
      e = sb[$];
      wait_out("rand", e.dz ? 5 : 71);
      consume("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weighted_mean_ctrl.md
WEIGHTED_MEAN_CTRL -- requirements
Module: weighted_mean_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the width of each sample and weight.
REQ-002 SHALL have parameter NCH, default 4, meaning the number of (sample, weight) channel pairs.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request carrying one sample/weight set.
REQ-006 SHALL have port in_ready  output  1  block can accept a set.
REQ-007 SHALL have port x_in  input  NCH*DW  samples, unsigned; channel i in bits [i*DW +: DW].
REQ-008 SHALL have port w_in  input  NCH*DW  weights, unsigned; same packing as x_in.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port mean  output  DW  floor(sum(x_i*w_i) / sum(w_i)).
REQ-012 SHALL have port div_by_zero  output  1  set when every weight was zero; mean is 0 in that case.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, MAC, DIV and OUT.
REQ-015 SHALL drive in_ready=1 only in IDLE; a handshake is in_valid&&in_ready, and x_in/w_in SHALL be registered on that edge.
REQ-016 SHALL, after the handshake, enter MAC with channel index 0 and clear both accumulators.
REQ-017 SHALL, in MAC, process one channel per cycle, ascending index: acc += x_i*w_i and wsum += w_i, using one shared multiplier.
REQ-018 SHALL size acc at 2*DW+clog2(NCH) bits and wsum at DW+clog2(NCH) bits, so neither accumulator can overflow.
REQ-019 SHALL, after channel NCH-1, go to OUT if wsum==0, with mean=0 and div_by_zero=1; otherwise it SHALL go to DIV.
REQ-020 SHALL, in DIV, perform unsigned restoring division acc/wsum, MSB first, one quotient bit per cycle, for exactly ACC_W cycles.
REQ-021 SHALL take mean from the low DW quotient bits; this is exact because the weighted mean never exceeds max x_i. The remainder SHALL be discarded (truncation).
REQ-022 SHALL drive out_valid=1 in OUT and hold mean/div_by_zero stable until out_valid&&out_ready; the FSM then returns to IDLE on that edge.
REQ-023 SHALL have fixed latency, with the handshake edge as cycle 0 (default parameters):
- MAC runs in cycles 1..4.
- DIV runs in cycles 5..70.
- out_valid rises at cycle 71.
- In the zero-weight case, out_valid rises at cycle 5.
REQ-024 SHALL ignore in_valid while busy; a held in_valid SHALL be accepted in the first IDLE cycle.
REQ-025 SHALL not start a new set in the cycle the result is consumed, giving a minimum of one IDLE cycle between sets.

Reset
REQ-026 SHALL, on reset, set the following on the next edge regardless of state, including mid-MAC or mid-DIV, discarding any partial result:
- state=IDLE;
- in_ready=1, out_valid=0, busy=0;
- mean=0, div_by_zero=0;
- acc=0, wsum=0, index=0, division counter=0.
REQ-027 SHALL give reset priority over in_valid and out_ready.

Structure
REQ-028 SHALL define the following in package weighted_mean_pkg:
- DW and NCH defaults;
- ACC_W and WS_W width constants;
- DIV_ITERS, equal to ACC_W;
- the FSM state enum.
REQ-029 SHALL place the divider in sub-module wm_serial_div, with start/done handshake, inputs num[ACC_W] and den[WS_W], and output quot[DW].

Verification
REQ-030 SHALL cover: x=10,20,30,40, w=1,1,1,1 -> mean=25, div_by_zero=0, out_valid at cycle 71.
REQ-031 SHALL cover: x=1,2,3,4, w=2,3,1,3 -> num=23, den=9, mean=2 (truncated).
REQ-032 SHALL cover: all w=0, x arbitrary -> mean=0, div_by_zero=1, out_valid at cycle 5.
REQ-033 SHALL cover: all x=all w=0xFFFFFFFF -> mean=0xFFFFFFFF, with no accumulator overflow.
REQ-034 SHALL cover: out_ready held low for 10 cycles in OUT -> mean stable, in_ready=0, and a second in_valid not accepted until after consumption.
REQ-035 SHALL cover: reset asserted at cycle 30 (mid-DIV) -> next edge shows state IDLE and all outputs at reset values; a new set then completes correctly.
